uart_tx_serializer: RTL



---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_counter.sv | 31 +++
 rtl/uart_tx_serializer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART datapath: TX state codes, idle line level
// and the parity helper.
package uart_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_POP    = 3'd1;
   localparam logic [2:0] ST_LOAD   = 3'd2;
   localparam logic [2:0] ST_START  = 3'd3;
   localparam logic [2:0] ST_DATA   = 3'd4;
   localparam logic [2:0] ST_PARITY = 3'd5;
   localparam logic [2:0] ST_STOP   = 3'd6;

   localparam logic LINE_IDLE = 1'b1;

   // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
   function automatic logic parity_of(input logic [7:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, wraps, and flags the last cycle.
// The count is exported so a receiver can derive a mid-bit sample point.
module uart_baud_counter #(
   parameter int CLKS_PER_BIT = 868,
   localparam int CNT_W = $clog2(CLKS_PER_BIT)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   output logic [CNT_W-1:0] count,
   output logic             bit_end
);

   logic [CNT_W-1:0] r_count;
   logic             w_last;

   assign w_last  = (r_count == CNT_W'(CLKS_PER_BIT - 1));
   assign count   = r_count;
   assign bit_end = w_last;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (clear || w_last) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: pops bytes from the TX FIFO and serialises them as
// start bit, LSB-first data, optional parity and one or two stop bits.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 tx_en,
   input  logic                 fifo_empty,
   input  logic [DATA_BITS-1:0] fifo_data,
   output logic                 fifo_rd_en,
   output logic                 tx,
   output logic                 tx_busy,
   output logic                 tx_done
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = 4;

   logic [2:0]           r_state;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_parity;
   logic [IDX_W-1:0]     r_bit_idx;
   logic                 r_tx;
   logic                 r_busy;
   logic                 r_done;

   logic                 w_start_ok;
   logic                 w_in_bit;
   logic                 w_bit_end;
   logic                 w_last_stop;
   logic                 w_done_next;
   logic [CNT_W-1:0]     w_count;
   logic [7:0]           w_data8;

   assign w_start_ok = tx_en & ~fifo_empty;
   assign w_data8    = 8'(fifo_data);

   always_comb begin
      w_in_bit = 1'b0;
      case (r_state)
         ST_START, ST_DATA, ST_PARITY, ST_STOP: w_in_bit = 1'b1;
         default:                               w_in_bit = 1'b0;
      endcase
   end

   // Held in clear outside bit states, so every bit state is entered at count 0.
   uart_baud_counter #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk    (clk),
      .reset  (reset),
      .clear  (~w_in_bit),
      .count  (w_count),
      .bit_end(w_bit_end)
   );

   assign w_last_stop = (r_state == ST_STOP) && (r_bit_idx == IDX_W'(STOP_BITS - 1));
   // tx_done is registered one cycle early so it lands on the final stop cycle.
   assign w_done_next = w_last_stop && (w_count == CNT_W'(CLKS_PER_BIT - 2));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_shift   <= '0;
         r_parity  <= 1'b0;
         r_bit_idx <= '0;
         r_tx      <= LINE_IDLE;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= w_done_next;
         case (r_state)
            ST_IDLE: begin
               r_tx <= LINE_IDLE;
               if (w_start_ok) begin
                  r_state <= ST_POP;
                  r_busy  <= 1'b1;
               end
            end
            ST_POP: begin
               r_state <= ST_LOAD;
            end
            ST_LOAD: begin
               r_shift  <= fifo_data;
               r_parity <= parity_of(w_data8, PARITY_ODD != 0);
               r_tx     <= 1'b0;
               r_state  <= ST_START;
            end
            ST_START: begin
               if (w_bit_end) begin
                  r_state   <= ST_DATA;
                  r_bit_idx <= '0;
                  r_tx      <= r_shift[0];
               end
            end
            ST_DATA: begin
               if (w_bit_end) begin
                  r_shift <= r_shift >> 1;
                  if (r_bit_idx == IDX_W'(DATA_BITS - 1)) begin
                     r_bit_idx <= '0;
                     if (PARITY_EN != 0) begin
                        r_state <= ST_PARITY;
                        r_tx    <= r_parity;
                     end else begin
                        r_state <= ST_STOP;
                        r_tx    <= LINE_IDLE;
                     end
                  end else begin
                     r_bit_idx <= r_bit_idx + 1'b1;
                     r_tx      <= r_shift[1];
                  end
               end
            end
            ST_PARITY: begin
               if (w_bit_end) begin
                  r_state <= ST_STOP;
                  r_tx    <= LINE_IDLE;
               end
            end
            ST_STOP: begin
               if (w_bit_end) begin
                  if (w_last_stop) begin
                     r_bit_idx <= '0;
                     if (w_start_ok) begin
                        r_state <= ST_POP;
                     end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                     end
                  end else begin
                     r_bit_idx <= r_bit_idx + 1'b1;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_tx    <= LINE_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign fifo_rd_en = (r_state == ST_POP);
   assign tx         = r_tx;
   assign tx_busy    = r_busy;
   assign tx_done    = r_done;

endmodule
